// File: rtl/apv_frame_emulator.sv
// APV25 digitized-frame transmitter: sync ticks while idle, one 140-cycle frame
// (12-bit digital header + 128 analog samples) per queued trigger.
module apv_frame_emulator #(
    parameter int       MAX_PENDING = 4,
    parameter bit [7:0] ADDR_INIT   = 8'h00
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        ENABLE,
    input  logic        TRIGGER,
    input  logic [7:0]  SYNC_PERIOD,
    input  logic [11:0] HIGH_LEVEL,
    input  logic [11:0] LOW_LEVEL,
    input  logic        HDR_ERR_N,
    input  logic [11:0] PATTERN_BASE,
    input  logic [11:0] PATTERN_STEP,
    output logic [11:0] ADC_PDATA,
    output logic        FRAME_ACTIVE,
    output logic        FRAME_DONE,
    output logic [2:0]  PENDING,
    output logic        TRIG_OVERFLOW
);
    localparam int PW = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t        state, nxt_state;
    logic [7:0]    cnt, nxt_cnt;
    logic [6:0]    idx, nxt_idx;
    logic [PW-1:0] pend, nxt_pend;
    logic          ovf, nxt_ovf;
    logic [7:0]    addr, nxt_addr;
    logic [8:0]    hdr_sr, nxt_hdr_sr;
    logic [11:0]   acc, nxt_acc;
    logic [11:0]   step_q, nxt_step_q;
    logic [11:0]   pdata, nxt_pdata;
    logic          active, nxt_active;
    logic          done, nxt_done;
    logic          start;

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state  <= IDLE;
            cnt    <= SYNC_PERIOD;
            idx    <= '0;
            pend   <= '0;
            ovf    <= 1'b0;
            addr   <= ADDR_INIT;
            hdr_sr <= '0;
            acc    <= '0;
            step_q <= '0;
            pdata  <= '0;
            active <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            idx    <= nxt_idx;
            pend   <= nxt_pend;
            ovf    <= nxt_ovf;
            addr   <= nxt_addr;
            hdr_sr <= nxt_hdr_sr;
            acc    <= nxt_acc;
            step_q <= nxt_step_q;
            pdata  <= nxt_pdata;
            active <= nxt_active;
            done   <= nxt_done;
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = cnt;
        nxt_idx    = idx;
        nxt_pend   = pend;
        nxt_ovf    = ovf;
        nxt_addr   = addr;
        nxt_hdr_sr = hdr_sr;
        nxt_acc    = acc;
        nxt_step_q = step_q;
        nxt_pdata  = LOW_LEVEL;
        nxt_active = 1'b0;
        nxt_done   = 1'b0;
        start      = 1'b0;

        unique case (state)
            IDLE: begin
                if (!ENABLE) begin
                    nxt_cnt = SYNC_PERIOD;
                end else if (cnt == 8'd0) begin
                    nxt_pdata = HIGH_LEVEL;
                    if (pend != '0) begin
                        // Slot becomes H0; everything the frame needs is captured here.
                        start      = 1'b1;
                        nxt_state  = HDR;
                        nxt_idx    = 7'd1;
                        nxt_active = 1'b1;
                        nxt_hdr_sr = {addr, HDR_ERR_N};
                        nxt_acc    = PATTERN_BASE;
                        nxt_step_q = PATTERN_STEP;
                    end else begin
                        nxt_cnt = SYNC_PERIOD;
                    end
                end else begin
                    nxt_cnt = cnt - 8'd1;
                end
            end
            HDR: begin
                nxt_active = 1'b1;
                nxt_idx    = idx + 7'd1;
                if (idx >= 7'd3) begin
                    nxt_pdata  = hdr_sr[8] ? HIGH_LEVEL : LOW_LEVEL;
                    nxt_hdr_sr = {hdr_sr[7:0], 1'b0};
                end else begin
                    nxt_pdata = HIGH_LEVEL;
                end
                if (idx == 7'd11) begin
                    nxt_state = DATA;
                    nxt_idx   = 7'd0;
                end
            end
            DATA: begin
                nxt_active = 1'b1;
                nxt_pdata  = acc;
                nxt_acc    = acc + step_q;
                nxt_idx    = idx + 7'd1;
                if (idx == 7'd127) begin
                    nxt_done  = 1'b1;
                    nxt_state = IDLE;
                    nxt_cnt   = SYNC_PERIOD;
                    nxt_addr  = addr + 8'd1;
                end
            end
            default: nxt_state = IDLE;
        endcase

        // A frame start and a new trigger in the same cycle cancel out.
        if (state == IDLE && !ENABLE) begin
            nxt_pend = '0;
            nxt_ovf  = 1'b0;
        end else if (TRIGGER && !start) begin
            if (pend == PW'(MAX_PENDING)) nxt_ovf = 1'b1;
            else                          nxt_pend = pend + PW'(1);
        end else if (!TRIGGER && start) begin
            nxt_pend = pend - PW'(1);
        end
    end

    assign ADC_PDATA     = pdata;
    assign FRAME_ACTIVE  = active;
    assign FRAME_DONE    = done;
    assign PENDING       = 3'(pend);
    assign TRIG_OVERFLOW = ovf;
endmodule

// File: tb/tb_apv_frame_emulator.sv
// Scoreboard bench: a frame-list reference model predicts every output cycle,
// a negedge monitor compares the DUT against it.
module tb_apv_frame_emulator;
    logic        CLK = 1'b0;
    logic        RSTb = 1'b0;
    logic        ENABLE = 1'b0;
    logic        TRIGGER = 1'b0;
    logic [7:0]  SYNC_PERIOD = 8'd34;
    logic [11:0] HIGH_LEVEL = 12'hC00;
    logic [11:0] LOW_LEVEL = 12'h200;
    logic        HDR_ERR_N = 1'b1;
    logic [11:0] PATTERN_BASE = 12'hFF0;
    logic [11:0] PATTERN_STEP = 12'h004;
    logic [11:0] ADC_PDATA;
    logic        FRAME_ACTIVE;
    logic        FRAME_DONE;
    logic [2:0]  PENDING;
    logic        TRIG_OVERFLOW;

    apv_frame_emulator #(.MAX_PENDING(4), .ADDR_INIT(8'hA5)) dut (
        .CLK(CLK), .RSTb(RSTb), .ENABLE(ENABLE), .TRIGGER(TRIGGER),
        .SYNC_PERIOD(SYNC_PERIOD), .HIGH_LEVEL(HIGH_LEVEL), .LOW_LEVEL(LOW_LEVEL),
        .HDR_ERR_N(HDR_ERR_N), .PATTERN_BASE(PATTERN_BASE), .PATTERN_STEP(PATTERN_STEP),
        .ADC_PDATA(ADC_PDATA), .FRAME_ACTIVE(FRAME_ACTIVE), .FRAME_DONE(FRAME_DONE),
        .PENDING(PENDING), .TRIG_OVERFLOW(TRIG_OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [11:0] d;
        logic        a;
        logic        dn;
        logic [2:0]  p;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: a frame is a list of 140 words built at its start.
    int m_frame[$];
    int m_cnt = 0;
    int m_pend = 0;
    bit m_ovf = 1'b0;
    int m_addr = 'hA5;

    always @(posedge CLK) begin : model
        exp_t e;
        bit   start;
        bit   trig_en;
        e = '0;
        start = 1'b0;
        trig_en = 1'b1;
        cyc++;
        if (!RSTb) begin
            m_cnt = SYNC_PERIOD;
            m_pend = 0;
            m_ovf = 1'b0;
            m_addr = 'hA5;
            m_frame.delete();
            trig_en = 1'b0;
        end else begin
            if (m_frame.size() > 0) begin
                e.d = 12'(m_frame.pop_front());
                e.a = 1'b1;
                if (m_frame.size() == 0) begin
                    e.dn = 1'b1;
                    m_cnt = SYNC_PERIOD;
                    m_addr = (m_addr + 1) % 256;
                end
            end else if (!ENABLE) begin
                e.d = LOW_LEVEL;
                m_cnt = SYNC_PERIOD;
                m_pend = 0;
                m_ovf = 1'b0;
                trig_en = 1'b0;
            end else if (m_cnt == 0) begin
                if (m_pend > 0) begin
                    for (int i = 0; i < 3; i++) m_frame.push_back(HIGH_LEVEL);
                    for (int b = 7; b >= 0; b--)
                        m_frame.push_back(((m_addr >> b) & 1) ? HIGH_LEVEL : LOW_LEVEL);
                    m_frame.push_back(HDR_ERR_N ? HIGH_LEVEL : LOW_LEVEL);
                    for (int n = 0; n < 128; n++)
                        m_frame.push_back((PATTERN_BASE + n * PATTERN_STEP) % 4096);
                    e.d = 12'(m_frame.pop_front());
                    e.a = 1'b1;
                    start = 1'b1;
                end else begin
                    e.d = HIGH_LEVEL;
                    m_cnt = SYNC_PERIOD;
                end
            end else begin
                e.d = LOW_LEVEL;
                m_cnt--;
            end
            if (trig_en) begin
                if (TRIGGER && !start) begin
                    if (m_pend == 4) m_ovf = 1'b1;
                    else m_pend++;
                end else if (!TRIGGER && start) begin
                    m_pend--;
                end
            end
        end
        e.p = 3'(m_pend);
        e.o = m_ovf;
        sb.push_back(e);
    end

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({ADC_PDATA, FRAME_ACTIVE, FRAME_DONE, PENDING, TRIG_OVERFLOW} !== e) begin
                errors++;
                $display("FAIL stream cyc=%0d got data=%h act=%b done=%b pend=%0d ovf=%b want data=%h act=%b done=%b pend=%0d ovf=%b",
                         cyc, ADC_PDATA, FRAME_ACTIVE, FRAME_DONE, PENDING, TRIG_OVERFLOW,
                         e.d, e.a, e.dn, e.p, e.o);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_left(input int n, input int limit, input string what);
        int k;
        k = 0;
        while (m_frame.size() != n && k < limit) begin
            @(negedge CLK);
            k++;
        end
        if (m_frame.size() != n) begin
            checks++;
            errors++;
            $display("FAIL timeout %s got left=%0d want left=%0d", what, m_frame.size(), n);
        end
    endtask

    task automatic pulse_trigger();
        TRIGGER = 1'b1;
        tick(1);
        TRIGGER = 1'b0;
    endtask

    initial begin
        int k;
        tick(3);
        RSTb = 1'b1;
        ENABLE = 1'b1;
        tick(80);                          // ticks every 35 cycles

        SYNC_PERIOD = 8'd0;
        tick(40);                          // constant HIGH
        SYNC_PERIOD = 8'd5;
        tick(10);

        pulse_trigger();                   // header A5, FF0 ramp with wrap
        wait_left(139, 50, "first frame start");
        wait_left(0, 200, "first frame end");
        tick(20);

        SYNC_PERIOD = 8'd34;
        ENABLE = 1'b0;
        tick(2);
        ENABLE = 1'b1;
        TRIGGER = 1'b1;                    // five triggers: 4 queued + overflow
        tick(5);
        TRIGGER = 1'b0;
        tick(4 * 180);

        SYNC_PERIOD = 8'd20;
        ENABLE = 1'b0;
        tick(2);
        ENABLE = 1'b1;
        TRIGGER = 1'b1;
        tick(4);
        TRIGGER = 1'b0;
        k = 0;
        while (!(m_cnt == 0 && m_frame.size() == 0) && k < 100) begin
            tick(1);
            k++;
        end
        if (!(m_cnt == 0 && m_frame.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL timeout coincident slot got cnt=%0d want cnt=0", m_cnt);
        end
        pulse_trigger();                   // coincides with frame start at PENDING=4
        tick(5 * 170);

        pulse_trigger();                   // reset during D50
        wait_left(77, 300, "reset point");
        RSTb = 1'b0;
        tick(1);
        RSTb = 1'b1;
        tick(30);

        pulse_trigger();                   // disable mid-frame
        wait_left(100, 300, "disable point");
        ENABLE = 1'b0;
        tick(120);
        ENABLE = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if (m_frame.size() == 0 && $urandom_range(49) == 0) begin
                HIGH_LEVEL   = 12'($urandom);
                LOW_LEVEL    = 12'($urandom);
                PATTERN_BASE = 12'($urandom);
                PATTERN_STEP = 12'($urandom);
                HDR_ERR_N    = 1'($urandom);
                SYNC_PERIOD  = 8'($urandom_range(12));
            end
            TRIGGER = ($urandom_range(24) == 0);
            if ($urandom_range(299) == 0) ENABLE = ~ENABLE;
            RSTb = ($urandom_range(1499) != 0);
            tick(1);
        end
        TRIGGER = 1'b0;
        RSTb = 1'b1;
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
